// File: rtl/pipe_muldiv_pkg.sv
// pipe_muldiv_pkg: op encodings, sequencer states and divide constants shared by the mul/div sequencer.
package pipe_muldiv_pkg;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  localparam int DIV_STEPS = 32;
  localparam logic [31:0] DZ_QUOTIENT = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
  function automatic logic [31:0] absVal(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/pipe_div_step.sv
// pipe_div_step: one restoring-division iteration, shifting one dividend bit into the partial remainder.
module pipe_div_step (
  input  logic [32:0] remIn,
  input  logic [31:0] quoIn,
  input  logic [31:0] divisor,
  output logic [32:0] remOut,
  output logic [31:0] quoOut
);
  logic [33:0] diff;
  assign diff = {remIn, quoIn[31]} - {2'b0, divisor};
  assign remOut = diff[33] ? {remIn[31:0], quoIn[31]} : diff[32:0];
  assign quoOut = {quoIn[30:0], ~diff[33]};
endmodule

// File: rtl/pipe_muldiv_seq.sv
// pipe_muldiv_seq: EXE-stage multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the pipeline stall and HI/LO.
// Optional MULDIV_EARLY_OUT_EN: divides by zero or with |rs|<|rt| finish one cycle after accept.
module pipe_muldiv_seq
  import pipe_muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o
);
  stateT state, stateNext;
  logic sgn, accept, earlyOut, dz;
  logic [31:0] opA, opB, dvs, quo, quoNext, quoFix, remFix, absA, absB;
  logic [32:0] rem, remNext;
  logic [4:0] cnt;
  logic [63:0] prod;
  assign accept = state == IDLE && start_i && !flush_i;
  assign busy_o = state == MUL || state == DIV;
  assign done_o = state == DONE;
  assign stall_o = accept || (busy_o && !flush_i);
  assign absA = absVal(rs_i, ~op_i[0]);
  assign absB = absVal(rt_i, ~op_i[0]);
`ifdef MULDIV_EARLY_OUT_EN
  assign earlyOut = op_i[1] && (rt_i == '0 || absA < absB);
`else
  assign earlyOut = 1'b0;
`endif
  // Low 64 bits of the sign-extended operands' product are the signed product.
  assign prod = {{32{sgn & opA[31]}}, opA} * {{32{sgn & opB[31]}}, opB};
  assign dz = opB == '0;
  assign quoFix = (sgn && (opA[31] ^ opB[31])) ? -quoNext : quoNext;
  assign remFix = (sgn && opA[31]) ? -remNext[31:0] : remNext[31:0];
  pipe_div_step uStep (
    .remIn(rem),
    .quoIn(quo),
    .divisor(dvs),
    .remOut(remNext),
    .quoOut(quoNext)
  );
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (accept) stateNext = earlyOut ? DONE : (op_i[1] ? DIV : MUL);
      MUL, DIV: stateNext = flush_i ? IDLE : (cnt == '0 ? DONE : state);
      DONE: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {sgn, opA, opB, dvs, quo, rem, cnt} <= '0;
      {hi_o, lo_o, dz_o} <= '0;
    end else if (accept) begin
      sgn <= ~op_i[0];
      opA <= rs_i;
      opB <= rt_i;
      dvs <= absB;
      quo <= absA;
      rem <= '0;
      cnt <= op_i[1] ? 5'(DIV_STEPS - 1) : 5'(MUL_CYCLES - 1);
      if (earlyOut) begin
        hi_o <= rs_i;
        lo_o <= rt_i == '0 ? DZ_QUOTIENT : '0;
        dz_o <= rt_i == '0;
      end
    end else if (busy_o && !flush_i) begin
      cnt <= cnt - 5'd1;
      rem <= remNext;
      quo <= quoNext;
      if (cnt == '0) begin
        hi_o <= state == MUL ? prod[63:32] : (dz ? opA : remFix);
        lo_o <= state == MUL ? prod[31:0] : (dz ? DZ_QUOTIENT : quoFix);
        dz_o <= state == DIV && dz;
      end
    end
endmodule

// File: doc/pipe_muldiv_seq.md
Name: pipe_muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer for the 5-stage pipeline. It is attached to the EXE stage.
- Accepts MULT/MULTU/DIV/DIVU issued from EXE.
- Holds the pipeline through stall_o while the operation iterates.
- Delivers HI/LO results for one cycle, with done_o, in the cycle the instruction is released.
- Feeds the existing stall net (PC and IF/ID hold) and the HI/LO write path.

Parameters:
MUL_CYCLES, 4, cycles spent in MUL state before DONE (legal 1..15).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low (rst=0 resets)
start_i  in  1  EXE holds a mul/div op; stays high while stalled
op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled at accept
rs_i  in  32  operand A / dividend; sampled at accept
rt_i  in  32  operand B / divisor; sampled at accept
flush_i  in  1  abort current op (branch/exception squash of EXE)
stall_o  out  1  hold PC, IF/ID, ID/EXE; bubble into EXE/MEM
busy_o  out  1  state is MUL or DIV
done_o  out  1  one-cycle pulse; hi_o/lo_o valid
hi_o  out  32  high product / remainder
lo_o  out  32  low product / quotient
dz_o  out  1  last completed op was a divide by zero; valid with done_o, held until next accept

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset (async, rst=0) gives IDLE, hi_o=lo_o=0, done_o=0, dz_o=0, counter=0.
- Accept: start_i=1 in IDLE and flush_i=0. Call this cycle T.
  - Operands and op are latched.
  - stall_o=1 combinationally in cycle T.
  - Next state is MUL if op[1]=0, otherwise DIV.
- stall_o = (IDLE & start_i & ~flush_i) | MUL | DIV. It is 0 in DONE, so the instruction advances in the DONE cycle.
- MUL: full 64-bit product, signed for MULT and unsigned for MULTU.
  - Product is registered at T+MUL_CYCLES.
  - DONE is in cycle T+MUL_CYCLES+1.
- DIV: 32-step restoring division on magnitudes, one quotient bit per cycle.
  - Steps run in cycles T+1..T+32. Down-counter runs 31..0.
  - Sign fix-up is registered at the end of T+32. DONE is in T+33.
  - Signed rules: quotient negative iff sign(rs)^sign(rt); remainder takes the sign of rs.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (rt=0): hi=rs, lo=0xFFFFFFFF, dz_o=1. Latency is the same as a normal divide unless the optional feature below is enabled.
- DONE: done_o=1 for exactly one cycle, then IDLE.
  - start_i is ignored in DONE because it belongs to the same instruction.
  - A new start_i in the following IDLE cycle is accepted normally, so back-to-back ops are legal.
- hi_o, lo_o and dz_o hold their value until the next DONE.
- flush_i:
  - In MUL or DIV: go to IDLE next cycle. No done_o. hi_o, lo_o and dz_o are unchanged. stall_o drops in the flush cycle.
  - In IDLE: blocks the accept.
  - In DONE: ignored; the result is already committed.
- start_i falling in MUL or DIV without flush_i is a protocol error. The sequencer continues regardless.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: a divide with rt=0, or |rs|<|rt|, skips the DIV state.
  - Results are written at the end of T. DONE is in T+1 and stall_o is high only in T.
  - Results: quotient 0 and remainder rs, or the divide-by-zero values for rt=0.
- Undefined: every divide takes the full 33-cycle stall.

Decomposition:
- Package pipe_muldiv_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state enum;
  - DIV_STEPS=32;
  - DZ_QUOTIENT=32'hFFFFFFFF.
- Sub-module pipe_div_step: one restoring iteration. It takes the partial remainder (33b), quotient and divisor, and returns the next remainder and quotient. It is purely combinational and instantiated once.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=2 -> done at T+5 (MUL_CYCLES=4); hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall_o high T..T+4.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7 -> done_o at T+33, lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=5, rt=0 -> hi=5, lo=0xFFFFFFFF, dz_o=1. Done at T+33, or T+1 with MULDIV_EARLY_OUT_EN.
- DIVU started, flush_i at T+10 -> IDLE at T+11, no done_o, hi/lo keep prior values; a new MULT at T+11 completes normally.
- rst=0 asserted mid-DIV at T+5 -> outputs zero immediately (async); after release, state is IDLE and stall_o=0.
